// File: rtl/dpram_arbiter.sv
// Dual-port RAM arbiter: round-robin picks up to two non-conflicting requesters per cycle, one per RAM port.
// Grants are combinational; reads return rvalid/rdata one cycle after grant; ungranted requesters hold their request.
module dpram_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 3,
  parameter int DW   = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [NREQ*DW-1:0]   rdata,
  output logic                 wr_en_a,
  output logic                 wr_en_b,
  output logic [AW-1:0]        addr_a,
  output logic [AW-1:0]        addr_b,
  output logic [DW-1:0]        data_in_a,
  output logic [DW-1:0]        data_in_b,
  input  logic [DW-1:0]        data_out_a,
  input  logic [DW-1:0]        data_out_b
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [AW-1:0]  addr_arr  [NREQ];
  logic [DW-1:0]  wdata_arr [NREQ];
  logic [DW-1:0]  rdata_arr [NREQ];

  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  a_idx, b_idx, j;
  logic           a_vld, b_vld;

  logic           rd_vld_a_q, rd_vld_a_d;
  logic           rd_vld_b_q, rd_vld_b_d;
  logic [PW-1:0]  rd_idx_a_q, rd_idx_a_d;
  logic [PW-1:0]  rd_idx_b_q, rd_idx_b_d;

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign addr_arr[g]           = req_addr[g*AW +: AW];
    assign wdata_arr[g]          = req_wdata[g*DW +: DW];
    assign rdata[g*DW +: DW]     = rdata_arr[g];
  end

  function automatic logic [PW-1:0] scan_idx(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Port A takes the first requester from ptr; port B the next one that does not clash with A.
  always_comb begin
    a_vld = 1'b0;
    b_vld = 1'b0;
    a_idx = '0;
    b_idx = '0;
    j     = '0;
    if (rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        j = scan_idx(ptr_q, k);
        if (req[j]) begin
          if (!a_vld) begin
            a_vld = 1'b1;
            a_idx = j;
          end else if (!b_vld &&
                       !((addr_arr[j] == addr_arr[a_idx]) && (req_we[j] || req_we[a_idx]))) begin
            b_vld = 1'b1;
            b_idx = j;
          end
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (a_vld) gnt[a_idx] = 1'b1;
    if (b_vld) gnt[b_idx] = 1'b1;

    wr_en_a   = a_vld & req_we[a_idx];
    addr_a    = a_vld ? addr_arr[a_idx]  : '0;
    data_in_a = a_vld ? wdata_arr[a_idx] : '0;
    wr_en_b   = b_vld & req_we[b_idx];
    addr_b    = b_vld ? addr_arr[b_idx]  : '0;
    data_in_b = b_vld ? wdata_arr[b_idx] : '0;

    ptr_d = ptr_q;
    if (b_vld)      ptr_d = scan_idx(b_idx, 1);
    else if (a_vld) ptr_d = scan_idx(a_idx, 1);

    rd_vld_a_d = a_vld & ~req_we[a_idx];
    rd_idx_a_d = a_idx;
    rd_vld_b_d = b_vld & ~req_we[b_idx];
    rd_idx_b_d = b_idx;
  end

  always_comb begin
    rvalid = '0;
    for (int g = 0; g < NREQ; g++) rdata_arr[g] = '0;
    if (rd_vld_a_q) begin
      rvalid[rd_idx_a_q]    = 1'b1;
      rdata_arr[rd_idx_a_q] = data_out_a;
    end
    if (rd_vld_b_q) begin
      rvalid[rd_idx_b_q]    = 1'b1;
      rdata_arr[rd_idx_b_q] = data_out_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      rd_vld_a_q <= 1'b0;
      rd_vld_b_q <= 1'b0;
      rd_idx_a_q <= '0;
      rd_idx_b_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rd_vld_a_q <= rd_vld_a_d;
      rd_vld_b_q <= rd_vld_b_d;
      rd_idx_a_q <= rd_idx_a_d;
      rd_idx_b_q <= rd_idx_b_d;
    end
  end

endmodule
